// File: rtl/weight_mem_loader.sv
// Weight memory loader: turns a counted valid/ready burst into sequential
// write strobes for the weight memory of one selected (layer, neuron).
module weight_mem_loader #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int selWidth     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic [selWidth-1:0]     cfg_layer,
    input  logic [selWidth-1:0]     cfg_neuron,
    input  logic [addressWidth:0]   cfg_count,
    input  logic                    s_valid,
    input  logic [dataWidth-1:0]    s_data,
    output logic                    s_ready,
    output logic                    wen,
    output logic [addressWidth:0]   waddr,
    output logic [dataWidth-1:0]    win,
    output logic [selWidth-1:0]     layer_sel,
    output logic [selWidth-1:0]     neuron_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [addressWidth:0]   wcount
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ERR} state_t;

    localparam logic [addressWidth:0] DEPTH = {1'b1, {addressWidth{1'b0}}};
    localparam logic [addressWidth:0] ONE   = {{addressWidth{1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_ready;
    logic                    r_wen;
    logic [addressWidth:0]   r_waddr;
    logic [dataWidth-1:0]    r_win;
    logic [selWidth-1:0]     r_layer;
    logic [selWidth-1:0]     r_neuron;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [addressWidth:0]   r_wcount;
    logic [addressWidth:0]   r_count;
    logic [addressWidth:0]   r_ptr;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_bad;
    logic                    w_start;

    assign w_accept = s_valid && r_ready;
    assign w_last   = w_accept && ((r_ptr + ONE) == r_count);
    assign w_bad    = (cfg_count == '0) || (cfg_count > DEPTH);
    assign w_start  = cfg_start && (r_state != S_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ERR: begin
                if (cfg_start) w_next = w_bad ? S_ERR : S_LOAD;
            end
            S_LOAD: begin
                if (w_last || cfg_abort) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs; the write lands one cycle after its accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready  <= 1'b0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_win    <= '0;
            r_layer  <= '0;
            r_neuron <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wcount <= '0;
            r_count  <= '0;
            r_ptr    <= '0;
        end else begin
            r_ready <= (w_next == S_LOAD);
            r_busy  <= (w_next == S_LOAD);
            r_wen   <= w_accept;
            r_done  <= w_last;
            if (w_accept) begin
                r_waddr  <= r_ptr;
                r_win    <= s_data;
                r_ptr    <= r_ptr + ONE;
                r_wcount <= r_wcount + ONE;
            end
            if (w_start) begin
                r_layer  <= cfg_layer;
                r_neuron <= cfg_neuron;
                r_count  <= cfg_count;
                r_ptr    <= '0;
                r_wcount <= '0;
                r_err    <= w_bad;
            end
        end
    end

    assign s_ready    = r_ready;
    assign wen        = r_wen;
    assign waddr      = r_waddr;
    assign win        = r_win;
    assign layer_sel  = r_layer;
    assign neuron_sel = r_neuron;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign wcount     = r_wcount;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Testbench for weight_mem_loader: directed and random bursts checked every
// cycle against a word-level model of the load.
module tb_weight_mem_loader;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int SW = 8;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [SW-1:0] cfg_layer = '0;
    logic [SW-1:0] cfg_neuron = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          wen;
    logic [CW-1:0] waddr;
    logic [DW-1:0] win;
    logic [SW-1:0] layer_sel;
    logic [SW-1:0] neuron_sel;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] wcount;

    always #5 clk = ~clk;

    weight_mem_loader #(
        .addressWidth(AW),
        .dataWidth   (DW),
        .selWidth    (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_layer (cfg_layer),
        .cfg_neuron(cfg_neuron),
        .cfg_count (cfg_count),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wen       (wen),
        .waddr     (waddr),
        .win       (win),
        .layer_sel (layer_sel),
        .neuron_sel(neuron_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wcount    (wcount)
    );

    int total = 0;
    int bad   = 0;

    // Word-level model of the load in progress
    bit m_active = 0;
    bit m_err    = 0;
    int m_cnt    = 0;
    int m_wr     = 0;
    int m_layer  = 0;
    int m_neuron = 0;
    bit e_wen    = 0;
    bit e_done   = 0;
    int e_waddr  = 0;
    int e_win    = 0;
    string phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h",
                   phase, tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input bit ab,
                       input int ly, input int nr, input int cn,
                       input bit v, input int d);
        bit acc;
        rst_n      = !rst;
        cfg_start  = st;
        cfg_abort  = ab;
        cfg_layer  = SW'(ly);
        cfg_neuron = SW'(nr);
        cfg_count  = CW'(cn);
        s_valid    = v;
        s_data     = DW'(d);
        if (rst) begin
            m_active = 0; m_err = 0; m_wr = 0; m_cnt = 0;
            m_layer = 0; m_neuron = 0;
            e_wen = 0; e_done = 0; e_waddr = 0; e_win = 0;
        end else begin
            acc    = m_active && v;
            e_wen  = acc;
            e_done = 0;
            if (acc) begin
                e_waddr = m_wr;
                e_win   = d & 16'hffff;
                m_wr++;
                e_done  = (m_wr == m_cnt);
            end
            if (!m_active && st) begin
                m_layer  = ly & 8'hff;
                m_neuron = nr & 8'hff;
                m_cnt    = cn;
                m_wr     = 0;
                m_err    = (cn == 0) || (cn > (1 << AW));
                m_active = !m_err;
            end else if (m_active && (e_done || ab)) begin
                m_active = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("s_ready", 32'(s_ready), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("wen", 32'(wen), 32'(e_wen));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(m_err));
        chk("wcount", 32'(wcount), 32'(m_wr));
        chk("waddr", 32'(waddr), 32'(e_waddr));
        chk("win", 32'(win), 32'(e_win));
        chk("layer_sel", 32'(layer_sel), 32'(m_layer));
        chk("neuron_sel", 32'(neuron_sel), 32'(m_neuron));
    endtask

    task automatic idle(input int n, input bit v);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, v, $urandom);
    endtask

    initial begin
        phase = "reset";
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 5);

        phase = "b2b";
        cyc(0, 1, 0, 1, 2, 4, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, i);
        idle(2, 0);
        chk("b2b_wcount", 32'(wcount), 32'd4);

        phase = "toggle";
        cyc(0, 1, 0, 1, 2, 4, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 0, 0, 0, (i % 2) == 1, i / 2 + 1);
        idle(3, 1);

        phase = "err";
        cyc(0, 1, 0, 3, 4, 0, 1, 0);
        idle(3, 1);
        cyc(0, 1, 1, 3, 4, 1025, 1, 0);
        idle(3, 1);
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 5, 6, 2, 0, 0);
        for (int i = 0; i < 20 && m_active; i++)
            cyc(0, 0, 0, 0, 0, 0, $urandom_range(0, 1) == 1, $urandom);
        idle(2, 1);

        phase = "full";
        cyc(0, 1, 0, 7, 9, 1024, 0, 0);
        for (int i = 0; i < 4000 && m_active; i++)
            cyc(0, 0, 0, 0, 0, 0, $urandom_range(0, 3) != 0, $urandom);
        chk("full_wcount", 32'(wcount), 32'd1024);
        idle(3, 1);

        phase = "abort";
        cyc(0, 1, 0, 2, 3, 8, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, $urandom);
        cyc(0, 1, 1, 9, 9, 3, 1, $urandom);
        idle(3, 1);
        chk("abort_wcount", 32'(wcount), 32'd4);

        phase = "midreset";
        cyc(0, 1, 0, 4, 4, 5, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 0, 1, $urandom);
        cyc(1, 0, 0, 0, 0, 0, 1, $urandom);
        idle(4, 1);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            int cn;
            cn = $urandom_range(0, 12);
            if ($urandom_range(0, 15) == 0) cn = 1024 + $urandom_range(0, 1);
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 255), $urandom_range(0, 255), cn,
                $urandom_range(0, 2) != 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_mem_loader.md
Name: weight_mem_loader

Overview:
- Write-side counterpart of the per-neuron weight memories.
- Accepts a configured burst of weights on a valid/ready stream and emits sequential write strobes (wen/waddr/win) into the weight memory of one selected (layer, neuron).
- Sits between the AXI config/register block and the weight memory array.
- Signals completion and configuration errors to software-visible status bits.

Parameters:
- addressWidth, 10, log2 of weight memory depth; depth = 2**addressWidth.
- dataWidth, 16, weight word width.
- selWidth, 8, width of layer and neuron select fields.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cfg_start  input  1  one-cycle pulse; latches cfg_* and begins a load.
- cfg_abort  input  1  one-cycle pulse; terminates an active load.
- cfg_layer  input  selWidth  target layer number.
- cfg_neuron  input  selWidth  target neuron number.
- cfg_count  input  addressWidth+1  number of weights to write.
- s_valid  input  1  weight word valid.
- s_data  input  dataWidth  weight word.
- s_ready  output  1  loader can accept a word this cycle.
- wen  output  1  write strobe to weight memory.
- waddr  output  addressWidth+1  write address (same width as the memory read address).
- win  output  dataWidth  write data.
- layer_sel  output  selWidth  latched target layer; qualifies wen.
- neuron_sel  output  selWidth  latched target neuron; qualifies wen.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse on the final write.
- err  output  1  sticky configuration error.
- wcount  output  addressWidth+1  words written in current/last load.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; s_ready, wen, busy, done, err=0; waddr, win, wcount, layer_sel, neuron_sel, internal pointer=0.
- Reset mid-load aborts immediately; no further wen is issued.
- States: IDLE, LOAD, ERR.
- All outputs are registered. s_ready = (state==LOAD) and is driven from a register.
- IDLE, on cfg_start:
  - Latch layer/neuron into layer_sel/neuron_sel; latch cfg_count; ptr=0; wcount=0; err=0.
  - If cfg_count==0 or cfg_count>2**addressWidth: go to ERR, err=1.
  - Otherwise go to LOAD.
- LOAD:
  - Beat accepted when s_valid && s_ready.
  - Next cycle: wen=1, waddr=ptr, win=s_data. ptr and wcount increment.
  - Latency from accepted beat to wen is exactly 1 cycle; one write per accepted beat; back-to-back beats give continuous wen.
  - When the accepted beat is number cfg_count (ptr==count-1): state→IDLE, s_ready=0 on the next cycle, and done=1 in the same cycle as that final wen.
  - No beat beyond cfg_count is ever accepted.
- wen is 0 in every cycle not immediately following an accepted beat. waddr and win hold their last values when wen=0.
- cfg_start during LOAD is ignored.
- cfg_abort during LOAD: state→IDLE, s_ready=0 next cycle, no done, err unchanged. A beat accepted in the same cycle as abort is still written (wen next cycle).
- cfg_abort in IDLE or ERR has no effect.
- ERR: s_ready=0; err stays 1 until the next cfg_start, which is evaluated exactly as in IDLE.
- Simultaneous cfg_start and cfg_abort in IDLE: start wins.
- Pointer never wraps: waddr ranges 0..cfg_count-1 (max 2**addressWidth-1).

Test Plan:
- Reset then cfg_start layer=1 neuron=2 count=4; stream 0x0001..0x0004 back-to-back → wen for 4 consecutive cycles, waddr 0,1,2,3, win 1..4, layer_sel=1, neuron_sel=2, done pulse coincident with waddr=3, wcount=4, busy low afterwards.
- Same load with s_valid toggling every other cycle → wen only one cycle after each accepted beat, addresses still contiguous 0..3, no duplicate writes.
- cfg_count=0, then cfg_count=1025 (addressWidth=10) → err=1, s_ready stays 0, no wen; then cfg_start count=2 → err clears and a normal 2-word load completes.
- Full-depth load count=1024 → last wen at waddr=1023, done asserted, s_ready drops; a 1025th s_valid is not accepted.
- cfg_abort after 3 of 8 beats, with a beat accepted in the abort cycle → exactly 4 writes (addr 0..3), no done, busy low, wcount=4.
- rst_n=0 mid-load after 2 beats → next cycle all outputs 0; s_valid held high produces no wen until a new cfg_start.
